// File: rtl/fu_pkg.sv
// Shared types for the pipelined integer functional unit: op codes, stage layout, stage limit.
// The MUL op codes are always declared; they only decode when FU_PIPE_MUL_EN is defined.
package fu_pkg;

  localparam int FU_MAX_STAGES = 4;

  localparam int FU_REG_SIZE = 32;
  localparam int FU_TAG_W    = 6;
  localparam int FU_ROB_W    = 6;

  typedef enum logic [3:0] {
    FU_ADD   = 4'b0000,
    FU_SUB   = 4'b0001,
    FU_SLL   = 4'b0010,
    FU_MUL   = 4'b0011,
    FU_SLT   = 4'b0100,
    FU_MULH  = 4'b0101,
    FU_SLTU  = 4'b0110,
    FU_MULHU = 4'b0111,
    FU_XOR   = 4'b1000,
    FU_SRL   = 4'b1010,
    FU_SRA   = 4'b1011,
    FU_OR    = 4'b1100,
    FU_AND   = 4'b1110
  } fu_op_t;

  // Stage layout for the default configuration; the top re-declares it with its own widths.
  typedef struct packed {
    logic                   valid;
    logic [FU_REG_SIZE-1:0] rd;
    logic [FU_TAG_W-1:0]    tag;
    logic [FU_ROB_W-1:0]    rob_index;
    logic                   loadstore;
  } fu_stage_t;

endpackage

// File: rtl/fu_alu_core.sv
// Combinational ALU: (op, rs1, rs2) -> result. Unknown codes yield 0.
// Multiply ops (MUL/MULH/MULHU) exist only when FU_PIPE_MUL_EN is defined.
module fu_alu_core
  import fu_pkg::*;
#(
  parameter int REG_SIZE = 32
) (
  input  fu_op_t              i_op,
  input  logic [REG_SIZE-1:0] i_rs1,
  input  logic [REG_SIZE-1:0] i_rs2,
  output logic [REG_SIZE-1:0] o_result
);

  localparam int SH_W = $clog2(REG_SIZE);

  logic [SH_W-1:0] w_shamt;
  assign w_shamt = i_rs2[SH_W-1:0];

`ifdef FU_PIPE_MUL_EN
  logic signed [2*REG_SIZE-1:0] w_prod_s;
  logic        [2*REG_SIZE-1:0] w_prod_u;
  assign w_prod_s = $signed(i_rs1) * $signed(i_rs2);
  assign w_prod_u = {{REG_SIZE{1'b0}}, i_rs1} * {{REG_SIZE{1'b0}}, i_rs2};
`endif

  always_comb begin
    o_result = '0;
    case (i_op)
      FU_ADD:  o_result = i_rs1 + i_rs2;
      FU_SUB:  o_result = i_rs1 - i_rs2;
      FU_SLL:  o_result = i_rs1 << w_shamt;
      FU_SLT:  o_result = {{(REG_SIZE-1){1'b0}}, ($signed(i_rs1) < $signed(i_rs2))};
      FU_SLTU: o_result = {{(REG_SIZE-1){1'b0}}, (i_rs1 < i_rs2)};
      FU_XOR:  o_result = i_rs1 ^ i_rs2;
      FU_SRL:  o_result = i_rs1 >> w_shamt;
      FU_SRA:  o_result = $signed(i_rs1) >>> w_shamt;
      FU_OR:   o_result = i_rs1 | i_rs2;
      FU_AND:  o_result = i_rs1 & i_rs2;
`ifdef FU_PIPE_MUL_EN
      FU_MUL:   o_result = w_prod_u[REG_SIZE-1:0];
      FU_MULH:  o_result = w_prod_s[2*REG_SIZE-1:REG_SIZE];
      FU_MULHU: o_result = w_prod_u[2*REG_SIZE-1:REG_SIZE];
`endif
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/functional_unit_pipe.sv
// Integer functional unit with NUM_STAGES elastic result stages, valid/ready on both sides and flush.
// Define FU_PIPE_MUL_EN to enable the multiply op codes in fu_alu_core.
module functional_unit_pipe
  import fu_pkg::*;
#(
  parameter int REG_SIZE      = 32,
  parameter int NUM_TAGS      = 64,
  parameter int ROB_SIZE      = 64,
  parameter int NUM_STAGES    = 2,
  parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
  parameter int ROB_SIZE_LOG2 = $clog2(ROB_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  fu_op_t                   op,
  input  logic [REG_SIZE-1:0]      rs1,
  input  logic [REG_SIZE-1:0]      rs2,
  input  logic [NUM_TAGS_LOG2-1:0] tags_in,
  input  logic [ROB_SIZE_LOG2-1:0] rob_index_in,
  input  logic                     loadstore_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_SIZE-1:0]      rd,
  output logic [NUM_TAGS_LOG2-1:0] tags_out,
  output logic [ROB_SIZE_LOG2-1:0] rob_index_out,
  output logic                     loadstore_out
);

  localparam int LAST = NUM_STAGES - 1;

  if (NUM_STAGES < 1 || NUM_STAGES > FU_MAX_STAGES) begin : g_bad_stages
    $error("functional_unit_pipe: NUM_STAGES must be in 1..%0d", FU_MAX_STAGES);
  end

  typedef struct packed {
    logic                     valid;
    logic [REG_SIZE-1:0]      rd;
    logic [NUM_TAGS_LOG2-1:0] tag;
    logic [ROB_SIZE_LOG2-1:0] rob_index;
    logic                     loadstore;
  } stage_t;

  logic [REG_SIZE-1:0]   w_result;
  logic [NUM_STAGES-1:0] w_free;
  stage_t                w_src   [NUM_STAGES];
  stage_t                r_stage [NUM_STAGES];

  fu_alu_core #(.REG_SIZE(REG_SIZE)) u_alu (
    .i_op     (op),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .o_result (w_result)
  );

  assign w_src[0] = '{valid: in_valid, rd: w_result, tag: tags_in,
                      rob_index: rob_index_in, loadstore: loadstore_in};

  // A stage is free if empty or if everything downstream of it moves this cycle.
  assign w_free[LAST] = !r_stage[LAST].valid || out_ready;

  for (genvar gi = 0; gi < LAST; gi++) begin : g_chain
    assign w_free[gi]    = !r_stage[gi].valid || w_free[gi+1];
    assign w_src[gi+1]   = r_stage[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) r_stage[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (flush)          r_stage[i].valid <= 1'b0;
        else if (w_free[i]) r_stage[i]       <= w_src[i];
      end
    end
  end

  assign in_ready      = w_free[0];
  assign out_valid     = r_stage[LAST].valid && !flush;
  assign rd            = r_stage[LAST].rd;
  assign tags_out      = r_stage[LAST].tag;
  assign rob_index_out = r_stage[LAST].rob_index;
  assign loadstore_out = r_stage[LAST].loadstore;

endmodule

// File: doc/functional_unit_pipe.md
Name: functional_unit_pipe

Overview:
- Parametrised successor to the single-cycle integer functional unit in the out-of-order core.
- Registers the ALU result through NUM_STAGES elastic pipeline stages, with a valid/ready handshake on both sides and a flush input for mispredict recovery.
- Corrects shift semantics and adds SLT/SLTU; an optional multiply path is available.
- Sits between the reservation station issue port and the CDB/LSQ arbiter.

Parameters:
- REG_SIZE, 32: operand/result width.
- NUM_TAGS, 64: physical register tags; NUM_TAGS_LOG2 = $clog2(NUM_TAGS).
- ROB_SIZE, 64: ROB entries; ROB_SIZE_LOG2 = $clog2(ROB_SIZE).
- NUM_STAGES, 2: pipeline register stages, legal range 1..4; values outside this range are an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept this cycle.
- op  in  4  operation code (fu_pkg::fu_op_t).
- rs1  in  REG_SIZE  operand 1.
- rs2  in  REG_SIZE  operand 2 or immediate.
- tags_in  in  NUM_TAGS_LOG2  rd tag.
- rob_index_in  in  ROB_SIZE_LOG2  ROB index.
- loadstore_in  in  1  op is address generation for the LSQ.
- flush  in  1  kill all in-flight ops.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- rd  out  REG_SIZE  result.
- tags_out  out  NUM_TAGS_LOG2  tag of result.
- rob_index_out  out  ROB_SIZE_LOG2  ROB index of result.
- loadstore_out  out  1  result is an address for the LSQ, not for the CDB.

Behaviour:
- Op codes:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
  - Any other code produces result 0, but the op still flows through the pipeline and is reported valid.
- Shift amount is rs2[$clog2(REG_SIZE)-1:0].
  - SRL is a logical right shift with zero fill.
  - SRA is an arithmetic right shift with sign fill on the signed value of rs1.
  - SLL is a logical left shift.
- SLT/SLTU produce result 1 or 0, zero-extended to REG_SIZE.
  - SLT compares signed; SLTU compares unsigned.
- ADD/SUB wrap modulo 2^REG_SIZE. No overflow flag.
- Datapath: the result is computed combinationally from the inputs, then captured into stage 0. Each stage holds {valid, rd, tag, rob_index, loadstore}.
- Stage advance rule:
  - The last stage is free when !valid[last] || out_ready.
  - Stage i (i < last) is free when !valid[i], or when stage i+1 is free.
  - in_ready equals "stage 0 free".
  - An input is accepted on in_valid && in_ready.
  - A stalled stage holds all of its fields unchanged.
- Latency: NUM_STAGES cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 op/cycle. No bubbles are inserted under continuous out_ready.
- Outputs are driven from the last stage: out_valid = valid[last] && !flush.
- Flush:
  - At the next rising edge all valid bits clear.
  - An input accepted in the flush cycle is discarded.
  - out_valid is forced low during the flush cycle, so no transfer occurs.
  - in_ready is unaffected by flush.
- Reset (rst_n low, asynchronous):
  - All valid bits and all data, tag, index and loadstore registers clear to 0.
  - Consequently out_valid=0, rd=0, tags_out=0, rob_index_out=0, loadstore_out=0, and in_ready=1.
  - Reset asserted mid-operation discards all in-flight ops immediately.
  - Release is synchronous to clk by the top-level synchroniser.
- Loadstore ops pass normally, with loadstore_out set; the downstream arbiter routes them to the LSQ. The valid signal is not gated by loadstore.
- Results on rd/tags_out/rob_index_out/loadstore_out when out_valid=0 are don't-care for checking; they hold the last stage contents.

Optional Feature:
- Macro: FU_PIPE_MUL_EN.
- When defined, adds three op codes:
  - MUL 0011: low REG_SIZE bits of the product.
  - MULH 0101: high REG_SIZE bits, signed x signed.
  - MULHU 0111: high REG_SIZE bits, unsigned x unsigned.
- The full 2*REG_SIZE product is computed in the pre-stage-0 logic; latency and handshake are unchanged.
- When undefined, codes 0011/0101/0111 fall into the default case and yield 0, and no multiplier is synthesised.

Decomposition:
- Package fu_pkg holds:
  - typedef enum logic [3:0] fu_op_t covering all codes, including the MUL codes, which are always declared.
  - typedef struct fu_stage_t {valid, rd, tag, rob_index, loadstore}.
  - localparam FU_MAX_STAGES = 4.
- One sub-module, fu_alu_core: purely combinational, (op, rs1, rs2) -> result, parametrised on REG_SIZE. It contains the MUL path under FU_PIPE_MUL_EN.
- functional_unit_pipe owns the stage array, the handshake and flush logic.

Test Plan:
1. Reset: rst_n low mid-stream with 2 ops in flight -> out_valid=0, rd=0 and in_ready=1 immediately; after release, no stale op ever emerges.
2. Latency/throughput: NUM_STAGES=2, out_ready=1, issue ADD 5+7 (tag 3, rob 9) then SUB 5-7 back-to-back -> rd=12/tag 3/rob 9 two cycles later, then rd=0xFFFFFFFE in the following cycle.
3. Shifts/compares:
   - SRA 0x80000000 by 4 -> 0xF8000000.
   - SRL same operands -> 0x08000000.
   - SLL 1 by rs2=0x21 -> 0x00000002 (amount masked to 1).
   - SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
4. Backpressure: out_ready=0 while issuing 3 ops, NUM_STAGES=2 -> in_ready drops after 2 accepts. Raising out_ready drains the ops in order with all fields intact.
5. Flush: flush asserted with 2 ops in flight and in_valid=1 -> out_valid=0 in the flush cycle and on all subsequent cycles until a new op is issued.
6. FU_PIPE_MUL_EN defined:
   - MULH 0xFFFFFFFF*0xFFFFFFFF -> 0.
   - MULHU same operands -> 0xFFFFFFFE.
   - MUL 6*7 -> 42.
   - Undefined build: MUL -> 0.
